// File: rtl/fp16_seq_pkg.sv
// rtl/fp16_seq_pkg.sv - shared types and constants for the FP16 add sequencer
package fp16_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_SUM,
        S_RESP
    } state_t;

    localparam int FLAG_SPECIAL       = 4;
    localparam int FLAG_SIGN_MISMATCH = 3;
    localparam int FLAG_UF            = 2;
    localparam int FLAG_OF            = 1;
    localparam int FLAG_INEXACT       = 0;

    localparam logic [15:0] QNAN      = 16'h7E00;
    localparam int          EXP_MAX   = 31;
    localparam int          ALIGN_MAX = 11;

endpackage

// File: rtl/fp16_rr_arbiter.sv
// rtl/fp16_rr_arbiter.sv - 2-way round-robin arbiter with pointer register
module fp16_rr_arbiter (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic       o_winner,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_winner = i_req[r_ptr] ? r_ptr : ~r_ptr;
        o_grant  = 2'b00;
        if (i_en && i_req[o_winner]) begin
            o_grant[o_winner] = 1'b1;
        end
    end

    // Pointer moves to the requester that lost, so a held request cannot starve the other
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr <= 1'b0;
        end else if (|o_grant) begin
            r_ptr <= ~o_winner;
        end
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// rtl/fp16_add_sequencer.sv - shares one FP16 magnitude-sum datapath between two requesters
// Define FP16_SEQ_BARREL_EN to align in a single cycle instead of one bit per cycle.
module fp16_add_sequencer
    import fp16_seq_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [15:0]       REQ0_A,
    input  logic [15:0]       REQ0_B,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [15:0]       REQ1_A,
    input  logic [15:0]       REQ1_B,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic              RSP_ID,
    output logic [15:0]       RSP_Q,
    output logic [4:0]        RSP_FLAGS,
    output logic [EXP_W-1:0]  DP_EXP,
    output logic [MANT_W-1:0] DP_MANT_A,
    output logic [MANT_W-1:0] DP_MANT_B,
    output logic              DP_STICKY,
    input  logic [15:0]       DP_Q,
    input  logic [4:0]        DP_FLAGS,
    output logic              BUSY
);

    state_t              r_state, w_next;
    logic                w_winner;
    logic [1:0]          w_grant;
    logic                r_id, r_sign, r_sticky;
    logic [15:0]         r_a, r_b, r_rsp_q;
    logic [4:0]          r_rsp_flags, w_sum_flags;
    logic [3:0]          r_count, w_cnt;
    logic [EXP_W-1:0]    r_dp_exp;
    logic [MANT_W-1:0]   r_mant_a, r_mant_b;

    logic [EXP_W-1:0]    w_ea, w_eb, w_eff_a, w_eff_b, w_big_e, w_small_e, w_diff;
    logic [MANT_W-1:0]   w_man_a, w_man_b, w_big_m, w_small_m;
    logic                w_swap, w_inf_a, w_inf_b, w_nan, w_special, w_mismatch;
    logic [15:0]         w_special_q;
    logic                w_unused;

    fp16_rr_arbiter u_arb (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_en     (r_state == S_IDLE),
        .i_req    ({REQ1_VALID, REQ0_VALID}),
        .o_winner (w_winner),
        .o_grant  (w_grant)
    );

    assign w_ea       = r_a[14:10];
    assign w_eb       = r_b[14:10];
    assign w_eff_a    = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eff_b    = (w_eb == '0) ? EXP_W'(1) : w_eb;
    assign w_man_a    = {w_ea != '0, r_a[9:0]};
    assign w_man_b    = {w_eb != '0, r_b[9:0]};
    assign w_inf_a    = (w_ea == EXP_W'(EXP_MAX));
    assign w_inf_b    = (w_eb == EXP_W'(EXP_MAX));
    assign w_nan      = (w_inf_a && r_a[9:0] != '0) || (w_inf_b && r_b[9:0] != '0);
    assign w_special  = w_inf_a || w_inf_b;
    assign w_mismatch = r_a[15] != r_b[15];
    // Both-Inf resolves to operand A's sign
    assign w_special_q = w_nan ? QNAN : {(w_inf_a ? r_a[15] : r_b[15]), 15'h7C00};

    assign w_swap    = w_eff_b > w_eff_a;
    assign w_big_e   = w_swap ? w_eff_b : w_eff_a;
    assign w_small_e = w_swap ? w_eff_a : w_eff_b;
    assign w_big_m   = w_swap ? w_man_b : w_man_a;
    assign w_small_m = w_swap ? w_man_a : w_man_b;
    assign w_diff    = w_big_e - w_small_e;
    assign w_cnt     = (w_diff > EXP_W'(ALIGN_MAX)) ? 4'(ALIGN_MAX) : w_diff[3:0];

`ifdef FP16_SEQ_BARREL_EN
    logic [MANT_W-1:0] w_mask;
    assign w_mask = ~({MANT_W{1'b1}} << r_count);
`endif

    always_comb begin
        w_sum_flags = '0;
        w_sum_flags[FLAG_UF:FLAG_INEXACT] = DP_FLAGS[FLAG_UF:FLAG_INEXACT];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (|w_grant) w_next = S_UNPACK;
            S_UNPACK: begin
                if (w_special || w_mismatch) w_next = S_RESP;
                else if (w_cnt != '0)        w_next = S_ALIGN;
                else                         w_next = S_SUM;
            end
`ifdef FP16_SEQ_BARREL_EN
            S_ALIGN:  w_next = S_SUM;
`else
            S_ALIGN:  if (r_count == 4'd1) w_next = S_SUM;
`endif
            S_SUM:    w_next = S_RESP;
            S_RESP:   if (RSP_READY) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_count     <= '0;
            r_dp_exp    <= '0;
            r_mant_a    <= '0;
            r_mant_b    <= '0;
            r_sticky    <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (|w_grant) begin
                    r_id <= w_winner;
                    r_a  <= w_winner ? REQ1_A : REQ0_A;
                    r_b  <= w_winner ? REQ1_B : REQ0_B;
                end
                S_UNPACK: begin
                    if (w_special) begin
                        r_rsp_q     <= w_special_q;
                        r_rsp_flags <= 5'(1 << FLAG_SPECIAL);
                    end else if (w_mismatch) begin
                        r_rsp_q     <= QNAN;
                        r_rsp_flags <= 5'(1 << FLAG_SIGN_MISMATCH);
                    end else begin
                        r_sign   <= r_a[15];
                        r_dp_exp <= w_big_e;
                        r_mant_a <= w_big_m;
                        r_mant_b <= w_small_m;
                        r_sticky <= 1'b0;
                        r_count  <= w_cnt;
                    end
                end
                S_ALIGN: begin
`ifdef FP16_SEQ_BARREL_EN
                    r_mant_b <= r_mant_b >> r_count;
                    r_sticky <= |(r_mant_b & w_mask);
                    r_count  <= '0;
`else
                    r_mant_b <= r_mant_b >> 1;
                    r_sticky <= r_sticky | r_mant_b[0];
                    r_count  <= r_count - 4'd1;
`endif
                end
                S_SUM: begin
                    r_rsp_q     <= {r_sign, DP_Q[14:0]};
                    r_rsp_flags <= w_sum_flags;
                end
                S_RESP: if (RSP_READY) begin
                    r_id        <= 1'b0;
                    r_dp_exp    <= '0;
                    r_mant_a    <= '0;
                    r_mant_b    <= '0;
                    r_sticky    <= 1'b0;
                    r_rsp_q     <= '0;
                    r_rsp_flags <= '0;
                end
                default: ;
            endcase
        end
    end

    assign w_unused   = ^{DP_Q[15], DP_FLAGS[4:3]};
    assign REQ0_READY = w_grant[0];
    assign REQ1_READY = w_grant[1];
    assign RSP_VALID  = (r_state == S_RESP);
    assign RSP_ID     = r_id;
    assign RSP_Q      = r_rsp_q;
    assign RSP_FLAGS  = r_rsp_flags;
    assign DP_EXP     = r_dp_exp;
    assign DP_MANT_A  = r_mant_a;
    assign DP_MANT_B  = r_mant_b;
    assign DP_STICKY  = r_sticky;
    assign BUSY       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// tb/tb_fp16_add_sequencer.sv - randomized self-checking bench for fp16_add_sequencer
module tb_fp16_add_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic        REQ0_READY, REQ1_READY;
    logic [15:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
    logic        RSP_VALID, RSP_ID, DP_STICKY, BUSY;
    logic        RSP_READY = 1'b1;
    logic [15:0] RSP_Q, DP_Q;
    logic [4:0]  RSP_FLAGS, DP_FLAGS, DP_EXP;
    logic [10:0] DP_MANT_A, DP_MANT_B;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] q;
        logic [4:0]  fl;
        logic [4:0]  lat;
        logic [4:0]  e;
        logic [10:0] ma;
        logic [10:0] mb;
        logic        st;
    } exp_t;

    always #5 CLK = ~CLK;

    fp16_add_sequencer #(.EXP_W(5), .MANT_W(11)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_Q(RSP_Q),
        .RSP_FLAGS(RSP_FLAGS), .DP_EXP(DP_EXP), .DP_MANT_A(DP_MANT_A), .DP_MANT_B(DP_MANT_B),
        .DP_STICKY(DP_STICKY), .DP_Q(DP_Q), .DP_FLAGS(DP_FLAGS), .BUSY(BUSY)
    );

    // Stand-in magnitude-sum datapath: truncating add with carry renormalisation
    function automatic logic [20:0] dp_fn(input logic [4:0] e, input logic [10:0] ma,
                                          input logic [10:0] mb, input logic st);
        int sum, ex;
        logic [10:0] m;
        logic inex, uf, of;
        logic [15:0] q;
        sum = int'(ma) + int'(mb);
        ex = int'(e);
        inex = st; uf = 1'b0; of = 1'b0;
        if (sum >= 2048) begin
            inex = inex | sum[0];
            m = 11'(sum / 2);
            ex = ex + 1;
        end else begin
            m = 11'(sum);
        end
        if (ex >= 31) begin
            q = 16'h7C00; of = 1'b1; inex = 1'b1;
        end else if (!m[10]) begin
            q = {6'd0, m[9:0]}; uf = inex;
        end else begin
            q = {1'b0, 5'(ex), m[9:0]};
        end
        return {2'b00, uf, of, inex, q};
    endfunction

    assign {DP_FLAGS, DP_Q} = dp_fn(DP_EXP, DP_MANT_A, DP_MANT_B, DP_STICKY);

    function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        int ea, eb, xa, xb, ma, mb, t, c;
        logic [20:0] d;
        r = '0;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 31 || eb == 31) begin
            if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) r.q = 16'h7E00;
            else if (ea == 31) r.q = {a[15], 15'h7C00};
            else r.q = {b[15], 15'h7C00};
            r.fl = 5'b10000; r.lat = 5'd1;
            return r;
        end
        if (a[15] != b[15]) begin
            r.q = 16'h7E00; r.fl = 5'b01000; r.lat = 5'd1;
            return r;
        end
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        ma = int'(a[9:0]) + ((ea != 0) ? 1024 : 0);
        mb = int'(b[9:0]) + ((eb != 0) ? 1024 : 0);
        if (xb > xa) begin
            t = xa; xa = xb; xb = t;
            t = ma; ma = mb; mb = t;
        end
        c = (xa - xb > 11) ? 11 : xa - xb;
        r.e  = 5'(xa);
        r.ma = 11'(ma);
        r.mb = 11'(mb / (1 << c));
        r.st = (mb % (1 << c)) != 0;
        d = dp_fn(r.e, r.ma, r.mb, r.st);
        r.q  = {a[15], d[14:0]};
        r.fl = {2'b00, d[18:16]};
`ifdef FP16_SEQ_BARREL_EN
        r.lat = (c > 0) ? 5'd3 : 5'd2;
`else
        r.lat = 5'(2 + c);
`endif
        return r;
    endfunction

    task automatic do_reset();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b1;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    // Issues one request and returns what was observed; assumes RSP_READY=1
    task automatic run_txn(input bit port, input logic [15:0] a, input logic [15:0] b,
                           output exp_t obs, output logic obs_id, output bit to);
        int n;
        obs = '0; obs_id = 1'b0; to = 1'b0;
        if (port) begin REQ1_VALID = 1'b1; REQ1_A = a; REQ1_B = b; end
        else      begin REQ0_VALID = 1'b1; REQ0_A = a; REQ0_B = b; end
        n = 0;
        while (!(port ? REQ1_READY : REQ0_READY)) begin
            @(posedge CLK); #1;
            n++;
            if (n > 50) begin
                to = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
                return;
            end
        end
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_A = 16'($urandom); REQ0_B = 16'($urandom);
        REQ1_A = 16'($urandom); REQ1_B = 16'($urandom);
        n = 0;
        while (!RSP_VALID && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!RSP_VALID) begin
            to = 1'b1;
            return;
        end
        obs.q = RSP_Q; obs.fl = RSP_FLAGS; obs.lat = 5'(n);
        obs.e = DP_EXP; obs.ma = DP_MANT_A; obs.mb = DP_MANT_B; obs.st = DP_STICKY;
        obs_id = RSP_ID;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        logic [52:0] outs;
        do_reset();
        outs = {RSP_VALID, RSP_ID, RSP_Q, RSP_FLAGS, DP_EXP, DP_MANT_A, DP_MANT_B, DP_STICKY,
                BUSY, REQ0_READY, REQ1_READY};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        #1;
        n_cmp++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
            n_fail++; $display("FAIL reset_ready_ptr0: got %b want 10", {REQ0_READY, REQ1_READY});
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [5] = '{16'h3C00, 16'h3C00, 16'h7800, 16'h7C00, 16'h3C00};
        logic [15:0] tb [5] = '{16'h3C00, 16'h3000, 16'h0001, 16'h3C00, 16'hBC00};
        logic [15:0] tq [5] = '{16'h4000, 16'h3C80, 16'h7800, 16'h7C00, 16'h7E00};
        logic [4:0]  tf [5] = '{5'b00000, 5'b00000, 5'b00001, 5'b10000, 5'b01000};
`ifdef FP16_SEQ_BARREL_EN
        int          tl [5] = '{2, 3, 3, 1, 1};
`else
        int          tl [5] = '{2, 5, 13, 1, 1};
`endif
        exp_t obs, ex;
        logic id;
        bit to;
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b0, ta[i], tb[i], obs, id, to);
            ex = ref_model(ta[i], tb[i]);
            n_cmp++;
            if (to) begin n_fail++; $display("FAIL dir%0d_timeout: no response", i); continue; end
            n_cmp++;
            if (obs.q !== tq[i] || obs.fl !== tf[i]) begin
                n_fail++; $display("FAIL dir%0d_result: got q=%h fl=%b want q=%h fl=%b",
                                   i, obs.q, obs.fl, tq[i], tf[i]);
            end
            n_cmp++;
            if (int'(obs.lat) != tl[i]) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, obs.lat, tl[i]);
            end
            n_cmp++;
            if ({obs.e, obs.ma, obs.mb, obs.st} !== {ex.e, ex.ma, ex.mb, ex.st}) begin
                n_fail++; $display("FAIL dir%0d_dp: got e=%0d a=%h b=%h s=%b want e=%0d a=%h b=%h s=%b",
                                   i, obs.e, obs.ma, obs.mb, obs.st, ex.e, ex.ma, ex.mb, ex.st);
            end
            n_cmp++;
            if (id !== 1'b0) begin n_fail++; $display("FAIL dir%0d_id: got %b want 0", i, id); end
        end
    endtask

    task automatic test_random();
        exp_t obs, ex;
        logic id;
        bit to, port;
        logic [15:0] a, b;
        for (int i = 0; i < 150; i++) begin
            port = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(3) != 0) b[15] = a[15];
            run_txn(port, a, b, obs, id, to);
            ex = ref_model(a, b);
            n_cmp++;
            if (to) begin n_fail++; $display("FAIL rnd%0d_timeout: a=%h b=%h", i, a, b); continue; end
            n_cmp++;
            if (obs !== ex || id !== port) begin
                n_fail++; $display("FAIL rnd%0d: a=%h b=%h got q=%h fl=%b lat=%0d dp=%h/%h/%h/%b id=%b want q=%h fl=%b lat=%0d dp=%h/%h/%h/%b id=%b",
                    i, a, b, obs.q, obs.fl, obs.lat, obs.e, obs.ma, obs.mb, obs.st, id,
                    ex.q, ex.fl, ex.lat, ex.e, ex.ma, ex.mb, ex.st, port);
            end
        end
    endtask

    task automatic test_arbitration();
        int n;
        do_reset();
        REQ0_VALID = 1'b1; REQ0_A = 16'h3C00; REQ0_B = 16'h3C00;
        REQ1_VALID = 1'b1; REQ1_A = 16'h4000; REQ1_B = 16'h4000;
        #1;
        n_cmp++;
        if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
            n_fail++; $display("FAIL arb_first_winner: got %b want 10", {REQ0_READY, REQ1_READY});
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!RSP_VALID && n < 40) begin @(posedge CLK); #1; n++; end
            n_cmp++;
            if (!RSP_VALID) begin n_fail++; $display("FAIL arb%0d_timeout: no response", k); break; end
            n_cmp++;
            if (RSP_ID !== 1'(k % 2) || RSP_Q !== ((k % 2) ? 16'h4400 : 16'h4000)) begin
                n_fail++; $display("FAIL arb%0d_order: got id=%b q=%h want id=%0d q=%h",
                                   k, RSP_ID, RSP_Q, k % 2, (k % 2) ? 16'h4400 : 16'h4000);
            end
            @(posedge CLK); #1;
        end
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] q0;
        logic [4:0] f0;
        logic [27:0] dp0;
        RSP_READY = 1'b0;
        REQ0_VALID = 1'b1; REQ0_A = 16'h3C00; REQ0_B = 16'h3000;
        n = 0;
        while (!REQ0_READY && n < 50) begin @(posedge CLK); #1; n++; end
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 40) begin @(posedge CLK); #1; n++; end
        n_cmp++;
        if (!RSP_VALID) begin n_fail++; $display("FAIL bp_timeout: no response"); end
        q0 = RSP_Q; f0 = RSP_FLAGS; dp0 = {DP_EXP, DP_MANT_A, DP_MANT_B, DP_STICKY};
        n_cmp++;
        if (q0 !== 16'h3C80) begin n_fail++; $display("FAIL bp_result: got %h want 3c80", q0); end
        REQ1_VALID = 1'b1; REQ1_A = 16'h4000; REQ1_B = 16'h4000;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if (!RSP_VALID || RSP_Q !== q0 || RSP_FLAGS !== f0 || RSP_ID !== 1'b0 ||
                {DP_EXP, DP_MANT_A, DP_MANT_B, DP_STICKY} !== dp0 || REQ0_READY || REQ1_READY) begin
                n_fail++; $display("FAIL bp_stall%0d: got v=%b q=%h fl=%b rdy=%b%b want v=1 q=%h fl=%b rdy=00",
                                   i, RSP_VALID, RSP_Q, RSP_FLAGS, REQ0_READY, REQ1_READY, q0, f0);
            end
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        n_cmp++;
        if (RSP_VALID !== 1'b0 || REQ1_READY !== 1'b1) begin
            n_fail++; $display("FAIL bp_next_accept: got v=%b rdy1=%b want v=0 rdy1=1", RSP_VALID, REQ1_READY);
        end
        @(posedge CLK); #1;
        REQ1_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 40) begin @(posedge CLK); #1; n++; end
        n_cmp++;
        if (RSP_Q !== 16'h4400 || RSP_ID !== 1'b1 || n != 2) begin
            n_fail++; $display("FAIL bp_second: got q=%h id=%b lat=%0d want q=4400 id=1 lat=2", RSP_Q, RSP_ID, n);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [51:0] outs;
        exp_t obs;
        logic id;
        bit to, seen;
        REQ0_VALID = 1'b1; REQ0_A = 16'h7800; REQ0_B = 16'h0001;
        n = 0;
        while (!REQ0_READY && n < 50) begin @(posedge CLK); #1; n++; end
        @(posedge CLK); #1;
        REQ0_VALID = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if (BUSY !== 1'b1 || DP_EXP !== 5'd30) begin
            n_fail++; $display("FAIL rm_in_align: got busy=%b exp=%0d want busy=1 exp=30", BUSY, DP_EXP);
        end
        RST_N = 1'b0;
        #1;
        outs = {RSP_VALID, RSP_ID, RSP_Q, RSP_FLAGS, DP_EXP, DP_MANT_A, DP_MANT_B, DP_STICKY,
                BUSY, REQ0_READY};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL rm_async_clear: got %h want 0", outs); end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            seen = seen | RSP_VALID | BUSY;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL rm_dropped: got activity=1 want 0"); end
        run_txn(1'b0, 16'h3C00, 16'h3C00, obs, id, to);
        n_cmp++;
        if (to || obs.q !== 16'h4000 || obs.lat !== 5'd2 || id !== 1'b0) begin
            n_fail++; $display("FAIL rm_recover: got to=%b q=%h lat=%0d id=%b want to=0 q=4000 lat=2 id=0",
                               to, obs.q, obs.lat, id);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
